mips_multicycle_ctrl: RTL and testbench

- Multicycle MIPS controller: a Moore FSM that sequences fetch, decode, execute, memory and writeback.
- Drives the datapath's mux selects and write enables.
- Produces the 3-bit ALU control word from opcode/funct and consumes the ALU `zero` flag to resolve branches.
- Sits between the instruction register (op/funct) and the shared datapath (single ALU, unified memory).

---
 rtl/mips_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller.
// A Moore FSM walks each instruction through fetch, decode, execute, memory
// and writeback, driving the shared datapath's mux selects and write enables.
// The ALU control word is decoded here from op/funct. The ALU zero flag only
// matters for resolving a beq.
//
// Handshake note: there is no valid/ready pairing on this block. The
// instruction register is loaded by ir_write, which is high only in FETCH.
// op/funct must then stay stable until the instruction returns to FETCH.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [2:0] alu_ctrl_sig,
  output logic [3:0] state
);

  // Opcodes of the supported ISA subset.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  // Ungated enables. The reset gating is applied on the output assigns.
  logic mem_write_d;
  logic ir_write_d;
  logic reg_write_d;
  logic pc_write;
  logic branch;

  // State register. An asynchronous reset abandons any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode. Every output takes its default first.
  always_comb begin
    state_d      = FETCH;
    mem_write_d  = 1'b0;
    ir_write_d   = 1'b0;
    reg_write_d  = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    i_or_d       = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    pc_src       = 2'b00;
    alu_ctrl_sig = ALU_ADD;

    case (state_q)
      FETCH: begin
        // PC + 4 goes through the ALU while the instruction is latched.
        alu_src_b  = 2'b01;
        ir_write_d = 1'b1;
        pc_write   = 1'b1;
        state_d    = DECODE;
      end

      DECODE: begin
        // Precompute the branch target PC + (SignImm << 2) into ALUOut.
        alu_src_b = 2'b11;
        case (op)
          OP_LW,
          OP_SW:    state_d = MEMADR;
          OP_RTYPE: state_d = RTYPEEX;
          OP_BEQ:   state_d = BEQEX;
          OP_ADDI:  state_d = ADDIEX;
          OP_J:     state_d = JEX;
          // Unknown opcodes retire as a nop.
          default:  state_d = FETCH;
        endcase
      end

      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == OP_LW) ? MEMRD : MEMWR;
      end

      MEMRD: begin
        i_or_d  = 1'b1;
        state_d = MEMWB;
      end

      MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_d = 1'b1;
        state_d     = FETCH;
      end

      MEMWR: begin
        i_or_d      = 1'b1;
        mem_write_d = 1'b1;
        state_d     = FETCH;
      end

      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        state_d   = RTYPEWB;
        case (funct)
          FN_ADD:  alu_ctrl_sig = ALU_ADD;
          FN_SUB:  alu_ctrl_sig = ALU_SUB;
          FN_AND:  alu_ctrl_sig = ALU_AND;
          FN_OR:   alu_ctrl_sig = ALU_OR;
          FN_SLT:  alu_ctrl_sig = ALU_SLT;
          default: begin
            // An unsupported funct skips writeback so no register is corrupted.
            alu_ctrl_sig = ALU_ADD;
            state_d      = FETCH;
          end
        endcase
      end

      RTYPEWB: begin
        reg_dst     = 1'b1;
        reg_write_d = 1'b1;
        state_d     = FETCH;
      end

      BEQEX: begin
        // Compare A and B. The target already sits in ALUOut from DECODE.
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b00;
        alu_ctrl_sig = ALU_SUB;
        pc_src       = 2'b01;
        branch       = 1'b1;
        state_d      = FETCH;
      end

      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end

      ADDIWB: begin
        reg_write_d = 1'b1;
        state_d     = FETCH;
      end

      JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = FETCH;
      end

      // Encodings 12-15 are unreachable. They keep the defaults and recover to FETCH.
      default: state_d = FETCH;
    endcase
  end

  // Write enables are held low while reset is asserted, even though FETCH
  // would otherwise raise ir_write and pc_en.
  assign mem_write = mem_write_d & rst_n;
  assign ir_write  = ir_write_d  & rst_n;
  assign reg_write = reg_write_d & rst_n;
  assign pc_en     = (pc_write | (branch & zero)) & rst_n;
  assign state     = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl.
// A table of per-cycle vectors holds {op, funct, zero, expected outputs}.
// The table is applied in order, starting from the first FETCH after reset.
// Hand-written sequences then cover reset asserted and released mid-instruction.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic [2:0] alu_ctrl_sig;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .funct        (funct),
    .zero         (zero),
    .mem_write    (mem_write),
    .i_or_d       (i_or_d),
    .ir_write     (ir_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .pc_src       (pc_src),
    .pc_en        (pc_en),
    .alu_ctrl_sig (alu_ctrl_sig),
    .state        (state)
  );

  // Clock block: 10 ns period. Rising edges fall at 5, 15, 25 ns and so on.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation bit order:
  // {state, mem_write, i_or_d, ir_write, reg_dst, mem_to_reg, reg_write,
  //  alu_src_a, alu_src_b, pc_src, pc_en, alu_ctrl_sig}
  logic [18:0] act;
  assign act = {state, mem_write, i_or_d, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, pc_src, pc_en, alu_ctrl_sig};

  function automatic logic [18:0] pk(input logic [3:0] st, input logic mw,
                                     input logic iod, input logic irw,
                                     input logic rd, input logic m2r,
                                     input logic rw, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] pcs,
                                     input logic pce, input logic [2:0] alu);
    return {st, mw, iod, irw, rd, m2r, rw, asa, asb, pcs, pce, alu};
  endfunction

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Scoreboard counters.
  int vectors_applied = 0;
  int miscompares     = 0;

  // Hand-computed expectations for each state's fixed outputs.
  logic [18:0] e_reset, e_fetch, e_decode, e_memadr, e_memrd, e_memwb, e_memwr;
  logic [18:0] e_rtypewb, e_addiex, e_addiwb, e_jex;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] ILL = 6'b111111;

  task automatic add(input string name, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [18:0] e);
    vec_t v;
    v.name = name;
    v.op = o;
    v.funct = f;
    v.zero = z;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [18:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (st|mw iod irw rd m2r rw asa asb pcs pce alu)",
               name, act, exp);
    end
  endtask

  // Driver: apply one vector just after a rising edge, check it at the falling
  // edge, then move on to the next rising edge.
  task automatic apply(input vec_t v);
    op    = v.op;
    funct = v.funct;
    zero  = v.zero;
    @(negedge clk);
    check(v.name, v.exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              st     mw    iod   irw   rd    m2r   rw    asa   asb    pcs    pce   alu
    e_reset   = pk(4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010);
    e_fetch   = pk(4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 3'b010);
    e_decode  = pk(4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 3'b010);
    e_memadr  = pk(4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010);
    e_memrd   = pk(4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010);
    e_memwb   = pk(4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010);
    e_memwr   = pk(4'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010);
    e_rtypewb = pk(4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010);
    e_addiex  = pk(4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010);
    e_addiwb  = pk(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010);
    e_jex     = pk(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 3'b010);

    // lw: 0,1,2,3,4. zero is toggled where it must be ignored.
    add("lw_fetch",  LW, 6'd0, 1'b1, e_fetch);
    add("lw_decode", LW, 6'd0, 1'b1, e_decode);
    add("lw_memadr", LW, 6'd0, 1'b1, e_memadr);
    add("lw_memrd",  LW, 6'd0, 1'b0, e_memrd);
    add("lw_memwb",  LW, 6'd0, 1'b1, e_memwb);
    // sw: 0,1,2,5.
    add("sw_fetch",  SW, 6'd0, 1'b0, e_fetch);
    add("sw_decode", SW, 6'd0, 1'b0, e_decode);
    add("sw_memadr", SW, 6'd0, 1'b0, e_memadr);
    add("sw_memwr",  SW, 6'd0, 1'b1, e_memwr);
    // R-type sub.
    add("sub_fetch",  RT, 6'b100010, 1'b0, e_fetch);
    add("sub_decode", RT, 6'b100010, 1'b0, e_decode);
    add("sub_ex",     RT, 6'b100010, 1'b1,
        pk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b110));
    add("sub_wb",     RT, 6'b100010, 1'b1, e_rtypewb);
    // R-type slt.
    add("slt_fetch",  RT, 6'b101010, 1'b0, e_fetch);
    add("slt_decode", RT, 6'b101010, 1'b0, e_decode);
    add("slt_ex",     RT, 6'b101010, 1'b0,
        pk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b111));
    add("slt_wb",     RT, 6'b101010, 1'b0, e_rtypewb);
    // R-type and / or / add: only the EX word differs.
    add("and_fetch",  RT, 6'b100100, 1'b0, e_fetch);
    add("and_decode", RT, 6'b100100, 1'b0, e_decode);
    add("and_ex",     RT, 6'b100100, 1'b0,
        pk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b000));
    add("and_wb",     RT, 6'b100100, 1'b0, e_rtypewb);
    add("or_fetch",   RT, 6'b100101, 1'b0, e_fetch);
    add("or_decode",  RT, 6'b100101, 1'b0, e_decode);
    add("or_ex",      RT, 6'b100101, 1'b0,
        pk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b001));
    add("or_wb",      RT, 6'b100101, 1'b0, e_rtypewb);
    add("add_fetch",  RT, 6'b100000, 1'b0, e_fetch);
    add("add_decode", RT, 6'b100000, 1'b0, e_decode);
    add("add_ex",     RT, 6'b100000, 1'b0,
        pk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b010));
    add("add_wb",     RT, 6'b100000, 1'b0, e_rtypewb);
    // Unsupported funct: 0,1,6 then straight back to FETCH with no writeback.
    add("badfn_fetch",  RT, 6'b000000, 1'b0, e_fetch);
    add("badfn_decode", RT, 6'b000000, 1'b0, e_decode);
    add("badfn_ex",     RT, 6'b000000, 1'b0,
        pk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b010));
    // beq taken: zero high in DECODE must not raise pc_en.
    add("beqt_fetch",  BEQ, 6'd0, 1'b0, e_fetch);
    add("beqt_decode", BEQ, 6'd0, 1'b1, e_decode);
    add("beqt_ex",     BEQ, 6'd0, 1'b1,
        pk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 3'b110));
    // beq not taken.
    add("beqn_fetch",  BEQ, 6'd0, 1'b1, e_fetch);
    add("beqn_decode", BEQ, 6'd0, 1'b0, e_decode);
    add("beqn_ex",     BEQ, 6'd0, 1'b0,
        pk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 3'b110));
    // j: 0,1,11.
    add("j_fetch",  J, 6'd0, 1'b0, e_fetch);
    add("j_decode", J, 6'd0, 1'b0, e_decode);
    add("j_ex",     J, 6'd0, 1'b0, e_jex);
    // Illegal op: 0,1 then back to FETCH.
    add("ill_fetch",  ILL, 6'd0, 1'b1, e_fetch);
    add("ill_decode", ILL, 6'd0, 1'b1, e_decode);
    // addi: 0,1,9,10 with zero held high.
    add("addi_fetch",  ADDI, 6'd0, 1'b1, e_fetch);
    add("addi_decode", ADDI, 6'd0, 1'b1, e_decode);
    add("addi_ex",     ADDI, 6'd0, 1'b1, e_addiex);
    add("addi_wb",     ADDI, 6'd0, 1'b1, e_addiwb);
    add("final_fetch", LW,   6'd0, 1'b0, e_fetch);

    // Reset phase: hold reset over a rising edge and check the outputs.
    rst_n = 1'b0;
    op    = LW;
    funct = 6'd0;
    zero  = 1'b1;
    @(negedge clk);
    check("reset_hold", e_reset);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven phase.
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Hand sequence: reset asserted mid-MEMRD, which abandons the lw.
    // The loop above leaves the design in DECODE for the lw.
    op   = LW;
    zero = 1'b0;
    @(negedge clk);
    check("mid_decode", e_decode);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_memadr", e_memadr);
    @(posedge clk);
    #1;
    check("mid_memrd", e_memrd);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", e_reset);
    @(negedge clk);
    check("async_reset_neg", e_reset);
    @(posedge clk);
    #1;
    check("async_reset_edge", e_reset);
    #2;
    rst_n = 1'b1;
    #1;
    check("release_fetch", e_fetch);
    @(posedge clk);
    #1;
    op = SW;
    check("release_decode", e_decode);
    @(posedge clk);
    #1;
    check("release_memadr", e_memadr);
    @(posedge clk);
    #1;
    check("release_memwr", e_memwr);
    @(posedge clk);
    #1;
    check("release_back", e_fetch);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
